mem_loader: RTL and testbench



---
 rtl/mem_loader.sv | 175 +++++++++++++++++
 tb/tb_mem_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Boot-time program loader: parses a {base, count} header from a byte stream and
// writes little-endian 32-bit words to memory. Optional check byte: LOADER_CHECKSUM_EN.
module mem_loader #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              axi_mem_w,
  output logic [ADDR_W-1:0] axi_mem_addr,
  output logic [DATA_W-1:0] axi_mem_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd6;
  localparam logic [2:0] S_TAIL  = S_CHK;
`else
  localparam logic [2:0] S_TAIL  = S_FIN;
`endif

  logic [2:0]        state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
  logic              err_q, err_d;
`endif

  logic        xfer;
  logic        last_byte;
  logic [31:0] word_asm;

  assign s_ready   = (state_q == S_ADDR) || (state_q == S_COUNT) || (state_q == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                   || (state_q == S_CHK)
`endif
                   ;
  assign xfer      = s_valid && s_ready;
  assign last_byte = xfer && (byte_cnt_q == 2'd3);
  // The first three bytes of a field sit in shift_q; the current byte completes it.
  assign word_asm  = {s_data, shift_q};

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path infers a latch.
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    base_d     = base_q;
    n_d        = n_q;
    k_d        = k_q;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = done_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d      = chk_q;
    err_d      = err_q;
`endif
    if (xfer) begin
      shift_d    = {s_data, shift_q[23:8]};
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
    case (state_q)
      S_IDLE: if (start) begin
        done_d     = 1'b0;
        byte_cnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
        err_d      = 1'b0;
        chk_d      = 8'h00;
`endif
        state_d    = S_ADDR;
      end
      S_ADDR: if (last_byte) begin
        base_d  = {word_asm[ADDR_W-1:2], 2'b00};
        state_d = S_COUNT;
      end
      S_COUNT: if (last_byte) begin
        n_d     = word_asm[CNT_W-1:0];
        k_d     = '0;
        state_d = (word_asm[CNT_W-1:0] == '0) ? S_TAIL : S_DATA;
      end
      S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer) chk_d = chk_q ^ s_data;
`endif
        if (last_byte) begin
          addr_d  = base_q + ADDR_W'({k_q, 2'b00});
          data_d  = DATA_W'(word_asm);
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        k_d     = k_q + CNT_W'(1);
        state_d = ((k_q + CNT_W'(1)) == n_q) ? S_TAIL : S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: if (xfer) begin
        if (s_data != chk_q) err_d = 1'b1;
        state_d = S_FIN;
      end
`endif
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      base_q     <= '0;
      n_q        <= '0;
      k_q        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      base_q     <= base_d;
      n_q        <= n_d;
      k_q        <= k_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
      err_q      <= err_d;
`endif
    end
  end

  assign axi_mem_w    = (state_q == S_WRITE);
  assign axi_mem_addr = addr_q;
  assign axi_mem_data = data_q;
  assign busy         = (state_q != S_IDLE);
  assign cpu_hold     = busy;
  assign done         = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: random byte gaps, expected writes computed
// from the header and word list; covers both LOADER_CHECKSUM_EN builds.
module tb_mem_loader;
  logic        clk = 1'b0;
  logic        reset, start, s_valid;
  logic [7:0]  s_data;
  logic        s_ready, axi_mem_w, busy, cpu_hold, done, err;
  logic [31:0] axi_mem_addr, axi_mem_data;

  mem_loader dut (
    .clk(clk), .reset(reset), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .axi_mem_w(axi_mem_w), .axi_mem_addr(axi_mem_addr),
    .axi_mem_data(axi_mem_data), .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [31:0] a; logic [31:0] d; time t; } wr_t;
  wr_t         wq[$];
  logic [31:0] words[$];
  time         tq[$];

  // Capture every write strobe seen between edges.
  always @(negedge clk) begin
    if (axi_mem_w === 1'b1) begin
      wq.push_back('{axi_mem_addr, axi_mem_data, $time});
      check("ready_low_in_write", {63'd0, s_ready}, 64'd0);
    end
  end

  // t = time of the negedge just before the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gmax, output time t);
    bit got = 1'b0;
    s_valid = 1'b0;
    repeat ($urandom_range(gmax, 0)) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = b;
    t = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (s_ready) begin got = 1'b1; t = $time; end
    end
    if (!got) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gmax, output time t);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gmax, t);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {58'd0, s_ready, axi_mem_w, busy, cpu_hold, done, err}, 64'd0);
    check({tag, "_addr"}, {32'd0, axi_mem_addr}, 64'd0);
    check({tag, "_data"}, {32'd0, axi_mem_data}, 64'd0);
  endtask

  // One full session; expected writes come from the header and words[].
  task automatic load(input logic [31:0] base, input logic [31:0] cnt_field,
                      input int gmax, input bit bad_chk);
    int          n = int'(cnt_field[15:0]);
    logic [7:0]  x = 8'h00;
    logic [31:0] base_al = base & 32'hFFFF_FFFC;
    logic [31:0] ea;
    bit          seen = 1'b0;
    time         t;
    pulse_start();
    check("busy_after_start", {61'd0, busy, cpu_hold, done}, 64'b110);
    wq.delete();
    tq.delete();
    send_word(base, gmax, t);
    send_word(cnt_field, gmax, t);
    for (int i = 0; i < n; i++) begin
      send_word(words[i], gmax, t);
      tq.push_back(t);
      x = x ^ words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x ^ {7'd0, bad_chk}, gmax, t);
`endif
    for (int i = 0; i < 3 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_set", {63'd0, done}, 64'd1);
    check("idle_after_done", {62'd0, busy, cpu_hold}, 64'd0);
`ifdef LOADER_CHECKSUM_EN
    check("err_flag", {63'd0, err}, {63'd0, bad_chk});
`else
    check("err_flag", {63'd0, err}, 64'd0);
`endif
    check("write_count", 64'(wq.size()), 64'(n));
    for (int i = 0; i < n && i < wq.size(); i++) begin
      ea = base_al + 32'(4 * i);
      check("write_addr", {32'd0, wq[i].a}, {32'd0, ea});
      check("write_data", {32'd0, wq[i].d}, {32'd0, words[i]});
      check("write_latency", 64'(wq[i].t), 64'(tq[i] + 10));
    end
  endtask

  initial begin
    time t;
    bit  rdy_seen;
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic load from the documented example.
    words = '{32'h1234_5678, 32'hDEAD_BEEF};
    load(32'h0000_1000, 32'd2, 0, 1'b0);

    // Zero count: no writes.
    words.delete();
    load(32'h0000_0020, 32'd0, 0, 1'b0);

    // Randomized gaps, bases and lengths.
    for (int s = 0; s < 4; s++) begin
      int n = $urandom_range(5, 1);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      load($urandom, 32'(n), 7, 1'b0);
    end

    // Address wrap and forced alignment.
    words = '{$urandom, $urandom};
    load(32'hFFFF_FFFF, 32'd2, 3, 1'b0);

    // Count field is truncated to its low 16 bits.
    words = '{$urandom, $urandom, $urandom};
    load(32'h0000_0800, 32'h0001_0003, 2, 1'b0);

    // Mid-session reset after 6 data bytes.
    pulse_start();
    send_word(32'h0000_0300, 0, t);
    send_word(32'd2, 0, t);
    send_word(32'hCAFE_F00D, 0, t);
    send_byte(8'h11, 0, t);
    send_byte(8'h22, 0, t);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    @(posedge clk); #1;
    words = '{$urandom};
    load(32'h0000_0400, 32'd1, 3, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    words = '{32'h0403_0201};
    load(32'h0000_0040, 32'd1, 0, 1'b0);
    load(32'h0000_0040, 32'd1, 0, 1'b1);
`endif

    // Bytes offered while idle are not consumed.
    wq.delete();
    rdy_seen = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    repeat (4) begin
      @(negedge clk);
      if (s_ready) rdy_seen = 1'b1;
    end
    s_valid = 1'b0;
    check("idle_no_ready", {63'd0, rdy_seen}, 64'd0);
    check("idle_no_write", 64'(wq.size()), 64'd0);

    // Reset wins over a simultaneous start.
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("reset_beats_start", {62'd0, busy, cpu_hold}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
